// File: rtl/wport_arbiter8_pkg.sv
// Shared types and helpers for the wport_arbiter8 round-robin arbiter.
package wport_arb_pkg;

    typedef enum logic {IDLE, OWN} arb_state_t;

    localparam int NREQ  = 8;
    localparam int IDX_W = 3;

    // Index of the first set bit of mask, scanning ptr, ptr+1, ... with
    // wrap-around modulo NREQ. Returns 0 when mask is empty.
    function automatic logic [IDX_W-1:0] rr_pick(
        input logic [NREQ-1:0]  mask,
        input logic [IDX_W-1:0] ptr
    );
        logic [IDX_W-1:0] idx;
        logic [IDX_W-1:0] result;
        result = '0;
        // Scan from the far end back towards ptr so the nearest hit wins last.
        for (int i = NREQ - 1; i >= 0; i--) begin
            idx = ptr + IDX_W'(i);
            if (mask[idx]) begin
                result = idx;
            end
        end
        return result;
    endfunction

endpackage

// File: rtl/decoder3_8.sv
// 3-to-8 one-hot decoder with enable; all outputs low when disabled.
module decoder3_8 (
    input  logic [2:0] i_sel,
    input  logic       i_en,
    output logic [7:0] o_y
);

    // Decode the select into a single asserted line when enabled.
    always_comb begin
        // NOTE: default assignment first so every path drives o_y and no latch is inferred.
        o_y = '0;
        if (i_en) begin
            o_y[i_sel] = 1'b1;
        end
    end

endmodule

// File: rtl/wport_arbiter8.sv
// wport_arbiter8: round-robin arbiter sharing one 8-way decoded resource
// (e.g. the register-file write port) among 8 requesters. The owner keeps
// the grant while its request stays high and is preempted after MAX_HOLD
// consecutive cycles when another requester is waiting. MAX_HOLD legal
// range is 1..8; CNT_W must be wide enough to hold MAX_HOLD-1.
//
// Optional feature (macro WPORT_ARB_LOCK_EN): adds an 8-bit lock input.
// While lock[owner] and req[owner] are both high the owner is never
// preempted; release behaviour is unchanged and non-owner lock bits are
// ignored. Without the macro the port is absent and preemption is always on.
module wport_arbiter8
    import wport_arb_pkg::*;
#(
    parameter int MAX_HOLD = 4,
    parameter int CNT_W    = 3
) (
    input  logic             clk,
    input  logic             reset_n,
`ifdef WPORT_ARB_LOCK_EN
    input  logic [NREQ-1:0]  lock,
`endif
    input  logic [NREQ-1:0]  req,
    output logic [NREQ-1:0]  gnt,
    output logic [IDX_W-1:0] gnt_idx,
    output logic             gnt_valid,
    output logic             preempt
);

    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(MAX_HOLD - 1);

    arb_state_t       r_state;
    logic [IDX_W-1:0] r_ptr;
    logic [IDX_W-1:0] r_owner;
    logic [CNT_W-1:0] r_hold_cnt;
    logic             r_gnt_valid;
    logic             r_preempt;

    arb_state_t       w_state_nxt;
    logic [IDX_W-1:0] w_ptr_nxt;
    logic [IDX_W-1:0] w_owner_nxt;
    logic [CNT_W-1:0] w_hold_nxt;
    logic             w_valid_nxt;
    logic             w_preempt_nxt;

    logic [NREQ-1:0]  w_others;
    logic [IDX_W-1:0] w_owner_plus1;
    logic             w_lock_hold;

    assign w_others      = req & ~(NREQ'(1) << r_owner);
    assign w_owner_plus1 = r_owner + IDX_W'(1);

`ifdef WPORT_ARB_LOCK_EN
    assign w_lock_hold = lock[r_owner];
`else
    assign w_lock_hold = 1'b0;
`endif

    // Next-state, pointer, owner and hold-counter logic.
    always_comb begin
        w_state_nxt   = r_state;
        w_ptr_nxt     = r_ptr;
        w_owner_nxt   = r_owner;
        w_hold_nxt    = r_hold_cnt;
        w_valid_nxt   = r_gnt_valid;
        w_preempt_nxt = 1'b0;

        case (r_state)
            IDLE: begin
                if (|req) begin
                    w_state_nxt = OWN;
                    w_owner_nxt = rr_pick(req, r_ptr);
                    w_hold_nxt  = '0;
                    w_valid_nxt = 1'b1;
                end
            end

            OWN: begin
                if (!req[r_owner]) begin
                    // Release: hand over with no idle gap if anyone else waits.
                    w_ptr_nxt  = w_owner_plus1;
                    w_hold_nxt = '0;
                    if (|w_others) begin
                        w_owner_nxt = rr_pick(w_others, w_owner_plus1);
                    end else begin
                        w_state_nxt = IDLE;
                        w_owner_nxt = '0;
                        w_valid_nxt = 1'b0;
                    end
                end else if ((|w_others) && (r_hold_cnt == HOLD_LAST) && !w_lock_hold) begin
                    // Hold limit reached with others pending: force a switch.
                    w_ptr_nxt     = w_owner_plus1;
                    w_owner_nxt   = rr_pick(w_others, w_owner_plus1);
                    w_hold_nxt    = '0;
                    w_preempt_nxt = 1'b1;
                end else if (r_hold_cnt != HOLD_LAST) begin
                    w_hold_nxt = r_hold_cnt + CNT_W'(1);
                end
            end

            default: begin
                w_state_nxt = IDLE;
                w_owner_nxt = '0;
                w_valid_nxt = 1'b0;
            end
        endcase
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments so every register samples pre-edge values.
        if (!reset_n) begin
            r_state     <= IDLE;
            r_ptr       <= '0;
            r_owner     <= '0;
            r_hold_cnt  <= '0;
            r_gnt_valid <= 1'b0;
            r_preempt   <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_ptr       <= w_ptr_nxt;
            r_owner     <= w_owner_nxt;
            r_hold_cnt  <= w_hold_nxt;
            r_gnt_valid <= w_valid_nxt;
            r_preempt   <= w_preempt_nxt;
        end
    end

    assign gnt_idx   = r_owner;
    assign gnt_valid = r_gnt_valid;
    assign preempt   = r_preempt;

    decoder3_8 u_gnt_dec (
        .i_sel (r_owner),
        .i_en  (r_gnt_valid),
        .o_y   (gnt)
    );

endmodule

// File: tb/tb_wport_arbiter8.sv
// Directed self-checking bench for wport_arbiter8 (default MAX_HOLD=4).
// Inputs change 1 time unit after a rising edge; outputs are sampled at
// the same point, so each check sees the state registered at that edge.
module tb_wport_arbiter8;

    logic       clk;
    logic       reset_n;
    logic [7:0] req;
    logic [7:0] gnt;
    logic [2:0] gnt_idx;
    logic       gnt_valid;
    logic       preempt;
`ifdef WPORT_ARB_LOCK_EN
    logic [7:0] lock;
`endif

    int n_pass  = 0;
    int n_total = 0;

    wport_arbiter8 dut (
        .clk       (clk),
        .reset_n   (reset_n),
`ifdef WPORT_ARB_LOCK_EN
        .lock      (lock),
`endif
        .req       (req),
        .gnt       (gnt),
        .gnt_idx   (gnt_idx),
        .gnt_valid (gnt_valid),
        .preempt   (preempt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    // Checks the full grant bundle: index, one-hot vector, valid, preempt.
    task automatic check_grant(input string tag, input logic v, input logic [2:0] idx, input logic p);
        logic [7:0] exp_gnt;
        exp_gnt = v ? (8'h01 << idx) : 8'h00;
        check({tag, ".gnt"},     gnt,              exp_gnt);
        check({tag, ".idx"},     8'(gnt_idx),      v ? 8'(idx) : 8'h00);
        check({tag, ".valid"},   8'(gnt_valid),    8'(v));
        check({tag, ".preempt"}, 8'(preempt),      8'(p));
    endtask

    initial begin
        // Expected owner / preempt per cycle for req=8'h06 with MAX_HOLD=4.
        logic [2:0] alt_idx [12];
        logic       alt_pre [12];
        alt_idx = '{3'd1, 3'd1, 3'd1, 3'd1, 3'd2, 3'd2, 3'd2, 3'd2, 3'd1, 3'd1, 3'd1, 3'd1};
        alt_pre = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};

        reset_n = 1'b0;
        req     = 8'hFF;
`ifdef WPORT_ARB_LOCK_EN
        lock    = 8'h00;
`endif

        // Reset held with all requests high: no grant.
        repeat (3) tick();
        check_grant("reset", 1'b0, 3'd0, 1'b0);

        // Reset released: ptr=0, so requester 0 wins.
        reset_n = 1'b1;
        tick();
        check_grant("post_reset", 1'b1, 3'd0, 1'b0);

        // Owner 0 releases with nobody else waiting -> idle, ptr=1.
        req = 8'h00;
        tick();
        check_grant("release_idle", 1'b0, 3'd0, 1'b0);

        // Sole requester 5 held for 10 cycles, never preempted.
        req = 8'h20;
        for (int i = 0; i < 10; i++) begin
            tick();
            check_grant($sformatf("single_c%0d", i + 1), 1'b1, 3'd5, 1'b0);
        end
        req = 8'h00;
        tick();
        check_grant("single_drop", 1'b0, 3'd0, 1'b0);

        // ptr=6: req=8'h06 picks 1, then alternates 1/2 every 4 cycles.
        req = 8'h06;
        for (int i = 0; i < 12; i++) begin
            tick();
            check_grant($sformatf("alt_c%0d", i + 1), 1'b1, alt_idx[i], alt_pre[i]);
        end
        req = 8'h00;
        tick();
        check_grant("alt_drop", 1'b0, 3'd0, 1'b0);

        // ptr=2: req=8'h88 picks 3; release to 7 with no idle gap.
        req = 8'h88;
        tick();
        check_grant("b2b_own3", 1'b1, 3'd3, 1'b0);
        req = 8'h80;
        tick();
        check_grant("b2b_own7", 1'b1, 3'd7, 1'b0);

        // Owner 7 keeps grant while 0 waits, then releases: ptr wraps to 0.
        req = 8'h81;
        tick();
        check_grant("wrap_hold7", 1'b1, 3'd7, 1'b0);
        req = 8'h41;
        tick();
        check_grant("wrap_own0", 1'b1, 3'd0, 1'b0);
        req = 8'h00;
        tick();
        check_grant("wrap_drop", 1'b0, 3'd0, 1'b0);

        // Mid-grant reset: ptr=1 picks 5, reset drops it, ptr restarts at 0.
        req = 8'h20;
        tick();
        check_grant("mid_own5", 1'b1, 3'd5, 1'b0);
        reset_n = 1'b0;
        tick();
        check_grant("mid_reset", 1'b0, 3'd0, 1'b0);
        reset_n = 1'b1;
        req     = 8'h21;
        tick();
        check_grant("mid_after", 1'b1, 3'd0, 1'b0);

        // Hold counter saturates while 0 is alone; a new waiter forces an
        // immediate switch once the limit is already reached.
        req = 8'h01;
        repeat (6) tick();
        check_grant("sat_hold0", 1'b1, 3'd0, 1'b0);
        req = 8'h03;
        tick();
        check_grant("sat_preempt", 1'b1, 3'd1, 1'b1);
        tick();
        check_grant("sat_pulse_end", 1'b1, 3'd1, 1'b0);
        req = 8'h00;
        tick();
        check_grant("sat_drop", 1'b0, 3'd0, 1'b0);

`ifdef WPORT_ARB_LOCK_EN
        // ptr=2: req=8'h06 picks 2; wait out one preempt to get owner 1.
        req = 8'h06;
        repeat (5) tick();
        check_grant("lock_start", 1'b1, 3'd1, 1'b1);
        lock = 8'h02;
        for (int i = 0; i < 20; i++) begin
            tick();
            check_grant($sformatf("lock_c%0d", i + 1), 1'b1, 3'd1, 1'b0);
        end
        lock = 8'h00;
        tick();
        check_grant("lock_off", 1'b1, 3'd2, 1'b1);
        req = 8'h00;
        tick();
        check_grant("lock_drop", 1'b0, 3'd0, 1'b0);
`endif

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/wport_arbiter8.md
Name: wport_arbiter8

Overview:
- Round-robin arbiter that shares one 8-way decoded resource among 8 requesters, e.g. the register-file write-enable decoder.
- Selects one requester, holds the grant while the request stays high, and preempts after MAX_HOLD cycles if others wait.
- Drives sel/en of a decoder3_8 instance to produce the one-hot grant vector.
- Sits between the pipeline write-back sources and the register-file write port.

Parameters:
- MAX_HOLD, 4: max consecutive grant cycles for one owner while another requester is pending; legal range 1..8.
- CNT_W, 3: width of the hold counter; must hold MAX_HOLD-1.

Ports:
- clk  input  1  rising-edge clock
- reset_n  input  1  synchronous, active-low reset
- req  input  8  level request per requester; bit i = requester i
- gnt  output  8  one-hot grant from the decoder3_8 instance; all zero when gnt_valid=0
- gnt_idx  output  3  index of current owner; 0 when gnt_valid=0
- gnt_valid  output  1  a grant is active this cycle
- preempt  output  1  one-cycle pulse: the grant switched because the hold limit expired

Behaviour:
- One clock, clk. Reset is synchronous and active-low on reset_n.
- Reset values: state=IDLE, ptr=0, hold_cnt=0, gnt_valid=0, gnt_idx=0, gnt=8'h00, preempt=0.
- Reset asserted mid-grant drops the grant on the next edge, with no completion.
- Priority search: first set bit of the candidate mask, scanning ptr, ptr+1, …, wrapping 7→0 (modulo 8).
- Latency: registered outputs. A req seen in cycle N gives gnt_valid=1 in cycle N+1.
- gnt = decoder3_8(sel=gnt_idx, en=gnt_valid), so gnt is always one-hot or zero.
- IDLE:
  - req==0: stay in IDLE.
  - Otherwise: owner = search(req). Go to OWN with hold_cnt=0.
- OWN, evaluated each cycle with others = req & ~(1<<owner):
  - req[owner]=0 (release): ptr=owner+1. If others≠0, grant search(others) next cycle with no idle gap and hold_cnt=0; else go to IDLE.
  - req[owner]=1, others≠0, hold_cnt==MAX_HOLD-1 (preempt): ptr=owner+1, new owner=search(others), hold_cnt=0, preempt=1 for that cycle.
  - req[owner]=1 otherwise: keep the owner. hold_cnt increments and saturates at MAX_HOLD-1.
  - Sole requester: held indefinitely, never preempted.
- MAX_HOLD=1: any pending other requester forces a switch every cycle, giving pure round-robin.
- A requester newly asserting in the same cycle as a release competes normally in the search.
- gnt_idx and gnt change only on clock edges, never combinationally from req.

Optional Feature:
- Macro WPORT_ARB_LOCK_EN.
- Defined:
  - Adds input port lock, 8 bits.
  - While lock[owner]=1 and req[owner]=1, the preempt rule is suppressed; hold_cnt still saturates.
  - Release behaviour is unchanged.
  - lock bits of non-owners are ignored.
- Undefined: port absent; preemption always active as above.

Decomposition:
- Shared package wport_arb_pkg holds:
  - typedef enum logic {IDLE, OWN} arb_state_t
  - localparam NREQ=8
  - localparam IDX_W=3
  - function rr_pick(mask, ptr) returning the 3-bit index of the first set bit at/after ptr
- Sub-module: reuse the existing decoder3_8 for gnt. No other sub-module.

Test Plan:
- Reset: hold reset_n=0 with req=8'hFF for 3 cycles → gnt=8'h00, gnt_valid=0, gnt_idx=0. Release reset → the next cycle gives gnt_idx=0, gnt=8'h01.
- Single requester: req=8'h20 for 10 cycles → gnt=8'h20 from cycle 1 through cycle 10, preempt never asserted. Then req=0 → gnt_valid=0 next cycle.
- Preemption with MAX_HOLD=4: req=8'h06 held → owner 1 for 4 cycles, then owner 2 with a preempt pulse, then owner 1 again after 4 cycles (alternating).
- Back-to-back release: owner 3, req goes from 8'h88 to 8'h80 → next cycle gnt_idx=7 with no idle cycle. Then req=8'h81 after owner 7 releases → owner 0 (wrap-around).
- Mid-grant reset: owner 5 active, reset_n=0 for 1 cycle → gnt=0 next cycle. After reset with req=8'h21, owner=0 because ptr was reset.
- With WPORT_ARB_LOCK_EN defined: req=8'h06, lock=8'h02 → owner 1 keeps the grant for 20 cycles with no preempt. Then lock=0 → switch to owner 2 within 1 cycle.
